// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline stages.
package core_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DONE
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/core_stage_fetch_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
interface core_stage_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, addr,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, addr,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/core_pc_next_sel.sv
// Next-PC priority mux: trap, then live branch, then pending branch, then pc+4.
module core_pc_next_sel (
  input  logic        i_trap_valid,
  input  logic [31:0] i_trap_pc,
  input  logic        i_pc_new_valid,
  input  logic [31:0] i_pc_new,
  input  logic        i_br_pending,
  input  logic [31:0] i_br_target,
  input  logic [31:0] i_pc,
  output logic [31:0] o_pc_next
);
  always_comb begin
    o_pc_next = i_pc + 32'd4;
    if (i_trap_valid) begin
      o_pc_next = i_trap_pc;
    end else if (i_pc_new_valid) begin
      o_pc_next = i_pc_new;
    end else if (i_br_pending) begin
      o_pc_next = i_br_target;
    end
  end
endmodule

// File: rtl/core_stage_fetch.sv
// Fetch stage: owns the architectural PC and fetches one instruction per request.
module core_stage_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_stage_valid,
  output logic                      fetch_stage_ready,
  input  logic                      pc_update,
  input  logic                      pc_new_valid,
  input  logic [31:0]               pc_new,
  input  logic                      trap_valid,
  input  logic [31:0]               trap_pc,
  core_stage_fetch_if.master        ibus,
  output logic [31:0]               instr,
  output logic [31:0]               pc,
  output logic                      ex_instr_access_fault
);
  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_br_target;
  logic         r_br_pending;
  logic         r_err_q;
  logic [31:0]  r_fetch_addr;
  logic [31:0]  w_pc_next;
  logic         w_resp_take;

  core_pc_next_sel u_pc_next_sel (
    .i_trap_valid   (trap_valid),
    .i_trap_pc      (trap_pc),
    .i_pc_new_valid (pc_new_valid),
    .i_pc_new       (pc_new),
    .i_br_pending   (r_br_pending),
    .i_br_target    (r_br_target),
    .i_pc           (r_pc),
    .o_pc_next      (w_pc_next)
  );

  assign w_resp_take = (r_state == FETCH_WAIT) && ibus.resp_valid;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      FETCH_IDLE: if (fetch_stage_valid) w_state_next = FETCH_REQ;
      FETCH_REQ:  if (ibus.req_ready)    w_state_next = FETCH_WAIT;
      FETCH_WAIT: if (ibus.resp_valid)   w_state_next = FETCH_DONE;
      FETCH_DONE: if (fetch_stage_valid) w_state_next = FETCH_IDLE;
      default:                           w_state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH_IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_br_target  <= 32'h0;
      r_br_pending <= 1'b0;
      r_err_q      <= 1'b0;
      r_fetch_addr <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (pc_update) begin
        r_pc <= w_pc_next;
      end
      // A branch arriving with pc_update is consumed directly by the mux.
      if (pc_update) begin
        r_br_pending <= 1'b0;
      end else if (pc_new_valid) begin
        r_br_pending <= 1'b1;
        r_br_target  <= pc_new;
      end
      // Snapshot the address so a stray pc_update cannot disturb an in-flight request.
      if (r_state == FETCH_IDLE && fetch_stage_valid) begin
        r_fetch_addr <= r_pc;
      end
      if (w_resp_take) begin
        r_instr <= ibus.resp_err ? NOP_INSTR : ibus.resp_rdata;
        r_err_q <= ibus.resp_err;
      end
    end
  end

  assign ibus.req_valid        = (r_state == FETCH_REQ);
  assign ibus.addr             = r_fetch_addr;
  assign fetch_stage_ready     = (r_state == FETCH_DONE);
  assign ex_instr_access_fault = (r_state == FETCH_DONE) && r_err_q && fetch_stage_valid;
  assign instr                 = r_instr;
  assign pc                    = r_pc;
endmodule

// File: tb/tb_core_stage_fetch.sv
// Directed bench for core_stage_fetch: fetch handshake, PC selection, faults, reset.
module tb_core_stage_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_stage_valid = 1'b0;
  logic        fetch_stage_ready;
  logic        pc_update = 1'b0;
  logic        pc_new_valid = 1'b0;
  logic [31:0] pc_new = 32'h0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ex_instr_access_fault;

  int total = 0;
  int bad = 0;

  core_stage_fetch_if ibus ();

  core_stage_fetch #(.RESET_PC(RST_PC)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .fetch_stage_valid     (fetch_stage_valid),
    .fetch_stage_ready     (fetch_stage_ready),
    .pc_update             (pc_update),
    .pc_new_valid          (pc_new_valid),
    .pc_new                (pc_new),
    .trap_valid            (trap_valid),
    .trap_pc               (trap_pc),
    .ibus                  (ibus.master),
    .instr                 (instr),
    .pc                    (pc),
    .ex_instr_access_fault (ex_instr_access_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete fetch; the bus accepts after `stall` cycles and responds next cycle.
  task automatic fetch(input logic [31:0] rdata, input logic err, input int stall,
                       input logic [31:0] exp_addr);
    fetch_stage_valid = 1'b1;
    ibus.req_ready = 1'b0;
    step();
    fetch_stage_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("req_valid_stall", {31'b0, ibus.req_valid}, 32'd1);
      chk("addr_stall", ibus.addr, exp_addr);
      step();
    end
    chk("req_valid", {31'b0, ibus.req_valid}, 32'd1);
    chk("req_addr", ibus.addr, exp_addr);
    ibus.req_ready = 1'b1;
    step();
    ibus.req_ready = 1'b0;
    ibus.resp_valid = 1'b1;
    ibus.resp_rdata = rdata;
    ibus.resp_err = err;
    #1;
    chk("req_dropped", {31'b0, ibus.req_valid}, 32'd0);
    chk("ready_in_wait", {31'b0, fetch_stage_ready}, 32'd0);
    step();
    ibus.resp_valid = 1'b0;
    ibus.resp_err = 1'b0;
    #1;
    chk("ready_done", {31'b0, fetch_stage_ready}, 32'd1);
    chk("instr", instr, err ? NOP : rdata);
    chk("fault_unqualified", {31'b0, ex_instr_access_fault}, 32'd0);
    fetch_stage_valid = 1'b1;
    #1;
    chk("fault_handshake", {31'b0, ex_instr_access_fault}, {31'b0, err});
    step();
    fetch_stage_valid = 1'b0;
    #1;
    chk("ready_after", {31'b0, fetch_stage_ready}, 32'd0);
    $display("fetch addr=%h instr=%h err=%0b stall=%0d", exp_addr, instr, err, stall);
  endtask

  task automatic do_update(input logic [31:0] exp_pc, input string tag);
    pc_update = 1'b1;
    step();
    pc_update = 1'b0;
    trap_valid = 1'b0;
    pc_new_valid = 1'b0;
    chk(tag, pc, exp_pc);
    $display("pc_update pc=%h", pc);
  endtask

  initial begin
    ibus.req_ready = 1'b0;
    ibus.resp_valid = 1'b0;
    ibus.resp_rdata = 32'h0;
    ibus.resp_err = 1'b0;
    #12;
    chk("rst_ready", {31'b0, fetch_stage_ready}, 32'd0);
    chk("rst_req", {31'b0, ibus.req_valid}, 32'd0);
    chk("rst_fault", {31'b0, ex_instr_access_fault}, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, NOP);
    step();
    rst_n = 1'b1;
    step();

    // 1: zero-wait fetch from reset PC
    fetch(32'h0050_0093, 1'b0, 0, 32'h8000_0000);
    // 2: sequential advance
    do_update(32'h8000_0004, "pc_plus4");
    fetch(32'h0010_0113, 1'b0, 0, 32'h8000_0004);
    // 3: pending branch consumed two cycles later
    pc_new_valid = 1'b1;
    pc_new = 32'h8000_0100;
    step();
    pc_new_valid = 1'b0;
    chk("pc_hold_branch", pc, 32'h8000_0004);
    step();
    do_update(32'h8000_0100, "pc_br_pending");
    do_update(32'h8000_0104, "pc_pending_cleared");
    // 4: trap beats a simultaneous branch
    trap_valid = 1'b1;
    trap_pc = 32'h8000_0040;
    pc_new_valid = 1'b1;
    pc_new = 32'h8000_0200;
    do_update(32'h8000_0040, "pc_trap");
    do_update(32'h8000_0044, "pc_no_pending");
    // 5: stalled request, faulting response
    fetch(32'hDEAD_BEEF, 1'b1, 3, 32'h8000_0044);
    do_update(32'h8000_0048, "pc_after_fault");
    fetch(32'h1234_5678, 1'b0, 1, 32'h8000_0048);
    // 6: reset while waiting for a response
    fetch_stage_valid = 1'b1;
    step();
    fetch_stage_valid = 1'b0;
    ibus.req_ready = 1'b1;
    step();
    ibus.req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, ibus.req_valid}, 32'd0);
    chk("mid_rst_pc", pc, RST_PC);
    chk("mid_rst_instr", instr, NOP);
    step();
    rst_n = 1'b1;
    ibus.resp_valid = 1'b1;
    ibus.resp_rdata = 32'hAAAA_AAAA;
    step();
    ibus.resp_valid = 1'b0;
    chk("stale_instr", instr, NOP);
    chk("stale_ready", {31'b0, fetch_stage_ready}, 32'd0);
    chk("stale_req", {31'b0, ibus.req_valid}, 32'd0);
    $display("reset mid-fetch pc=%h instr=%h", pc, instr);
    fetch(32'h0000_0073, 1'b0, 0, RST_PC);
    // 7: pc+4 wraps
    trap_valid = 1'b1;
    trap_pc = 32'hFFFF_FFFC;
    do_update(32'hFFFF_FFFC, "pc_top");
    do_update(32'h0000_0000, "pc_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
